// File: rtl/diferential_muxpga_driver_if.sv
// Host-side handshake bundle for the muxpga pin driver.
// master: host (start/stop, cfg and run streams); slave: the driver.
interface diferential_muxpga_driver_if;
   logic       start;
   logic       stop;
   logic       cfg_valid;
   logic [3:0] cfg_nibble;
   logic       cfg_ready;
   logic       run_valid;
   logic [3:0] run_nibble;
   logic       run_ready;
   logic       res_valid;
   logic [7:0] res_data;
   logic       loaded;

   modport master (
      output start, stop,
      output cfg_valid, cfg_nibble,
      output run_valid, run_nibble,
      input  cfg_ready, run_ready,
      input  res_valid, res_data, loaded
   );

   modport slave (
      input  start, stop,
      input  cfg_valid, cfg_nibble,
      input  run_valid, run_nibble,
      output cfg_ready, run_ready,
      output res_valid, res_data, loaded
   );
endinterface

// File: rtl/diferential_muxpga_driver.sv
// Sequencer driving the muxpga 8-bit pin bus: fabric reset, config load,
// then run beats. Ports: clk, reset (async high), host (slave modport),
// pin_out {cmd[1:0], nibble[3:0], pin reset, pin clock}, pin_in (fabric io_out).
module diferential_muxpga_driver #(
   parameter int NIBBLES      = 24,
   parameter int RESET_CYCLES = 2
) (
   input  logic                          clk,
   input  logic                          reset,
   diferential_muxpga_driver_if.slave    host,
   output logic [7:0]                    pin_out,
   input  logic [7:0]                    pin_in
);

   localparam int MAXC = (NIBBLES > RESET_CYCLES) ? NIBBLES : RESET_CYCLES;
   localparam int CW   = $clog2(MAXC + 1);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RST  = 2'd1;
   localparam logic [1:0] S_LOAD = 2'd2;
   localparam logic [1:0] S_RUN  = 2'd3;

   localparam logic [1:0] CMD_CFG  = 2'd0;
   localparam logic [1:0] CMD_RUN  = 2'd1;
   localparam logic [1:0] CMD_HOLD = 2'd2;

   logic [1:0]    state, state_d;
   logic [CW-1:0] cnt, cnt_d, cnt_inc;
   logic [7:0]    pin_q, pin_d;
   logic          res_valid_q, res_valid_d;
   logic [7:0]    res_data_q, res_data_d;
   logic          ph;
   logic          cfg_acc, run_acc;

   // pin clock is the low bit of the registered pin bus
   assign ph      = pin_q[0];
   assign cnt_inc = cnt + CW'(1);

   assign cfg_acc = (state == S_LOAD) & ~ph & host.cfg_valid;
   // stop wins over a simultaneous run_valid
   assign run_acc = (state == S_RUN) & ~ph & host.run_valid & ~host.stop;

   always_comb begin
      state_d     = state;
      cnt_d       = cnt;
      pin_d       = pin_q;
      res_valid_d = 1'b0;
      res_data_d  = res_data_q;
      unique case (state)
         S_IDLE: begin
            pin_d = {CMD_HOLD, 4'h0, 2'b00};
            if (host.start) begin
               state_d = S_RST;
               cnt_d   = '0;
               pin_d   = {CMD_CFG, 4'h0, 2'b10};
            end
         end
         S_RST: begin
            if (!ph) begin
               pin_d[0] = 1'b1;
            end else begin
               pin_d[0] = 1'b0;
               if (cnt_inc == CW'(RESET_CYCLES)) begin
                  state_d = S_LOAD;
                  cnt_d   = '0;
                  pin_d   = {CMD_CFG, 4'h0, 2'b00};
               end else begin
                  cnt_d = cnt_inc;
               end
            end
         end
         S_LOAD: begin
            if (!ph) begin
               // no cfg_valid: hold ph=0, no pin edge
               if (cfg_acc) begin
                  pin_d = {CMD_CFG, host.cfg_nibble, 2'b01};
               end
            end else begin
               pin_d[0] = 1'b0;
               if (cnt_inc == CW'(NIBBLES)) begin
                  state_d = S_RUN;
                  cnt_d   = '0;
                  pin_d   = {CMD_RUN, 4'h0, 2'b00};
               end else begin
                  cnt_d = cnt_inc;
               end
            end
         end
         S_RUN: begin
            if (!ph) begin
               if (host.stop) begin
                  state_d = S_IDLE;
                  cnt_d   = '0;
                  pin_d   = {CMD_HOLD, 4'h0, 2'b00};
               end else if (run_acc) begin
                  pin_d = {CMD_RUN, host.run_nibble, 2'b01};
               end
            end else begin
               // fabric output has settled after the run edge
               pin_d[0]    = 1'b0;
               res_valid_d = 1'b1;
               res_data_d  = pin_in;
               if (cnt != '1) begin
                  cnt_d = cnt_inc;
               end
            end
         end
         default: begin
            state_d = S_IDLE;
            cnt_d   = '0;
            pin_d   = {CMD_HOLD, 4'h0, 2'b00};
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= S_IDLE;
         cnt         <= '0;
         pin_q       <= 8'h00;
         res_valid_q <= 1'b0;
         res_data_q  <= 8'h00;
      end else begin
         state       <= state_d;
         cnt         <= cnt_d;
         pin_q       <= pin_d;
         res_valid_q <= res_valid_d;
         res_data_q  <= res_data_d;
      end
   end

   assign pin_out        = pin_q;
   assign host.cfg_ready = cfg_acc;
   assign host.run_ready = run_acc;
   assign host.res_valid = res_valid_q;
   assign host.res_data  = res_data_q;
   assign host.loaded    = (state == S_RUN);

endmodule
